// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with MEM priority and an IF starvation cap.
// Issue to response takes at least 3 cycles; one bus transaction is outstanding at a time.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   output logic                if_stall_o,
   input  logic                flush_i,

   input  logic                mem_req_i,
   input  logic                mem_we_i,
   input  logic [DATA_W/8-1:0] mem_be_i,
   input  logic [ADDR_W-1:0]   mem_addr_i,
   input  logic [DATA_W-1:0]   mem_wdata_i,
   output logic                mem_gnt_o,
   output logic                mem_rvalid_o,
   output logic [DATA_W-1:0]   mem_rdata_o,
   output logic                mem_stall_o,

   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [DATA_W/8-1:0] bus_be_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   input  logic                bus_gnt_i,
   input  logic                bus_rvalid_i,
   input  logic [DATA_W-1:0]   bus_rdata_i
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ISSUE    = 2'd1;
   localparam logic [1:0] WAIT_RSP = 2'd2;

   localparam logic OWN_IF  = 1'b0;
   localparam logic OWN_MEM = 1'b1;

   logic [1:0] state;
   logic       owner;
   logic       drop;
   logic [3:0] starve_cnt;

   logic contested;
   logic starved;
   logic if_win;
   logic mem_win;
   logic rsp_fire;

   always_comb begin
      contested = if_req_i & mem_req_i;
      starved   = (starve_cnt == 4'(STARVE_LIMIT));
      if_win    = (state == IDLE) & if_req_i & (~mem_req_i | starved);
      mem_win   = (state == IDLE) & mem_req_i & ~if_win;
      rsp_fire  = (state == WAIT_RSP) & bus_rvalid_i;
   end

   // Requester-facing outputs are combinational; reset forces them low even mid-transaction.
   always_comb begin
      if_gnt_o     = ~rst & if_win;
      mem_gnt_o    = ~rst & mem_win;
      if_rvalid_o  = ~rst & rsp_fire & (owner == OWN_IF) & ~drop & ~flush_i;
      mem_rvalid_o = ~rst & rsp_fire & (owner == OWN_MEM);
      if_rdata_o   = rst ? '0 : bus_rdata_i;
      mem_rdata_o  = rst ? '0 : bus_rdata_i;
      if_stall_o   = ~rst & ((if_req_i & ~if_rvalid_o) | drop);
      mem_stall_o  = ~rst & mem_req_i & ~mem_rvalid_o;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= OWN_IF;
         drop        <= 1'b0;
         starve_cnt  <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_be_o    <= '0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (if_win) begin
                  state       <= ISSUE;
                  owner       <= OWN_IF;
                  starve_cnt  <= '0;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_be_o    <= '1;
                  bus_addr_o  <= if_addr_i;
                  bus_wdata_o <= '0;
               end else if (mem_win) begin
                  state       <= ISSUE;
                  owner       <= OWN_MEM;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= mem_we_i;
                  bus_be_o    <= mem_be_i;
                  bus_addr_o  <= mem_addr_i;
                  bus_wdata_o <= mem_wdata_i;
                  if (contested) begin
                     starve_cnt <= starve_cnt + 4'd1;
                  end
               end
            end
            ISSUE: begin
               if (bus_gnt_i) begin
                  state     <= WAIT_RSP;
                  bus_req_o <= 1'b0;
               end
            end
            WAIT_RSP: begin
               if (bus_rvalid_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A redirected fetch still drains on the bus; its response is swallowed.
         if (rsp_fire) begin
            drop <= 1'b0;
         end else if (flush_i && (owner == OWN_IF) && (state == ISSUE || state == WAIT_RSP)) begin
            drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors, expected grants/responses queued, monitor compares.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        if_stall_o;
   logic        flush_i;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [3:0]  mem_be_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic        mem_gnt_o;
   logic        mem_rvalid_o;
   logic [31:0] mem_rdata_o;
   logic        mem_stall_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   mem_port_arbiter #(.STARVE_LIMIT(3), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
      .flush_i(flush_i),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_gnt_o(mem_gnt_o),
      .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_stall_o(mem_stall_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        who;   // 0 = IF, 1 = MEM
      logic        chk;
      logic [31:0] dat;
   } rsp_t;

   rsp_t rsp_q[$];
   logic gnt_q[$];
   int   checks   = 0;
   int   failures = 0;

   int          gnt_dly = 0;
   int          rsp_dly = 0;
   logic        stray   = 1'b0;
   int          wcnt    = 0;
   int          rcnt    = 0;
   logic        pend    = 1'b0;
   logic [31:0] la      = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_rdata(input logic [31:0] a);
      return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
   endfunction

   task automatic exp_rsp(input logic who, input logic chk, input logic [31:0] dat);
      rsp_t r;
      r.who = who;
      r.chk = chk;
      r.dat = dat;
      rsp_q.push_back(r);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bus slave: grants after gnt_dly waiting cycles, responds rsp_dly cycles after grant.
   initial begin
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus_gnt_i    = 1'b0;
         bus_rvalid_i = 1'b0;
         if (rst) begin
            pend = 1'b0;
            wcnt = 0;
         end else if (stray) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = 32'hBAD0_BAD0;
         end else if (pend) begin
            if (rcnt == 0) begin
               bus_rvalid_i = 1'b1;
               bus_rdata_i  = model_rdata(la);
               pend         = 1'b0;
            end else begin
               rcnt--;
            end
         end else if (bus_req_o) begin
            if (wcnt == gnt_dly) begin
               bus_gnt_i = 1'b1;
               la        = bus_addr_o;
               pend      = 1'b1;
               rcnt      = rsp_dly;
               wcnt      = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   // Monitor: every grant and every response is matched against the scoreboard queues.
   initial begin
      forever begin
         @(negedge clk);
         if (if_gnt_o || mem_gnt_o) begin
            if (gnt_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_gnt actual=%b%b required=none", if_gnt_o, mem_gnt_o);
            end else begin
               logic g;
               g = gnt_q.pop_front();
               check("gnt_owner", {62'd0, if_gnt_o, mem_gnt_o}, g ? 64'd1 : 64'd2);
            end
         end
         if (if_rvalid_o || mem_rvalid_o) begin
            if (rsp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp actual=%b%b required=none", if_rvalid_o, mem_rvalid_o);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               check("rsp_owner", {62'd0, if_rvalid_o, mem_rvalid_o}, r.who ? 64'd1 : 64'd2);
               if (r.chk) begin
                  check("rsp_data", r.who ? mem_rdata_o : if_rdata_o, r.dat);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      if_req_i = 0; if_addr_i = '0; flush_i = 0;
      mem_req_i = 0; mem_we_i = 0; mem_be_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
      step();
      step();
      @(negedge clk);
      check("rst_bus_ctl", {bus_req_o, bus_we_o, bus_be_o}, 0);
      check("rst_bus_addr", bus_addr_o, 0);
      check("rst_req_side", {if_gnt_o, if_rvalid_o, if_stall_o, mem_gnt_o, mem_rvalid_o, mem_stall_o}, 0);
      step();
      rst = 1'b0;
      step();

      // IF-only fetch, immediate bus
      step();
      if_req_i = 1; if_addr_i = 32'h0000_0100;
      gnt_q.push_back(1'b0);
      exp_rsp(1'b0, 1'b1, 32'h0000_0013);
      @(negedge clk);
      check("t1_c0_gnt", if_gnt_o, 1);
      check("t1_c0_stall", if_stall_o, 1);
      check("t1_c0_busreq", bus_req_o, 0);
      step();
      @(negedge clk);
      check("t1_c1_busreq", bus_req_o, 1);
      check("t1_c1_addr", bus_addr_o, 32'h0000_0100);
      check("t1_c1_webe", {bus_we_o, bus_be_o}, 5'b0_1111);
      check("t1_c1_stall", if_stall_o, 1);
      step();
      @(negedge clk);
      check("t1_c2_rvalid", if_rvalid_o, 1);
      check("t1_c2_rdata", if_rdata_o, 32'h0000_0013);
      check("t1_c2_stall", if_stall_o, 0);
      step();
      if_req_i = 0;
      repeat (2) step();

      // Contested: MEM first, IF after MEM response
      if_req_i = 1; if_addr_i = 32'h0000_0200;
      mem_req_i = 1; mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h0000_2000;
      gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
      exp_rsp(1'b1, 1'b1, 32'hC0DE_2000);
      exp_rsp(1'b0, 1'b1, 32'hC0DE_0200);
      for (int c = 0; c < 8; c++) begin
         logic gi, gm;
         @(negedge clk);
         gi = if_gnt_o;
         gm = mem_gnt_o;
         if (c == 3) check("t2_if_gnt_after_mem", gi, 1);
         step();
         if (gi) if_req_i = 0;
         if (gm) mem_req_i = 0;
      end

      // Both held: MEM, MEM, MEM, IF, MEM
      if_req_i = 1; if_addr_i = 32'h0000_0500;
      mem_req_i = 1; mem_addr_i = 32'h0000_4000;
      gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
      gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
      exp_rsp(1'b1, 1'b1, 32'hC0DE_4000);
      exp_rsp(1'b1, 1'b1, 32'hC0DE_4000);
      exp_rsp(1'b1, 1'b1, 32'hC0DE_4000);
      exp_rsp(1'b0, 1'b1, 32'hC0DE_0500);
      exp_rsp(1'b1, 1'b1, 32'hC0DE_4000);
      n = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         @(negedge clk);
         n = n + int'(if_gnt_o) + int'(mem_gnt_o);
         step();
      end
      if_req_i = 0; mem_req_i = 0;
      check("t3_grant_count", n, 5);
      repeat (4) step();

      // Store with delayed bus grant
      gnt_dly = 4;
      mem_req_i = 1; mem_we_i = 1; mem_be_i = 4'b0011;
      mem_addr_i = 32'h0000_3000; mem_wdata_i = 32'hDEAD_BEEF;
      gnt_q.push_back(1'b1);
      exp_rsp(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      check("t4_mem_stall", mem_stall_o, 1);
      step();
      mem_req_i = 0; mem_we_i = 0; mem_be_i = '0; mem_wdata_i = '0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("t4_busreq", bus_req_o, 1);
         check("t4_webe", {bus_we_o, bus_be_o}, 5'b1_0011);
         check("t4_addr", bus_addr_o, 32'h0000_3000);
         check("t4_wdata", bus_wdata_o, 32'hDEAD_BEEF);
         check("t4_busgnt", bus_gnt_i, (k == 5) ? 1 : 0);
         step();
      end
      @(negedge clk);
      check("t4_rvalid", mem_rvalid_o, 1);
      step();
      gnt_dly = 0;
      repeat (2) step();

      // Flush during IF wait: response swallowed, next fetch normal
      rsp_dly = 2;
      if_req_i = 1; if_addr_i = 32'h0000_0600;
      gnt_q.push_back(1'b0);
      step();
      if_req_i = 0;
      step();
      flush_i = 1;
      step();
      flush_i = 0;
      @(negedge clk);
      check("t5_drain_stall", if_stall_o, 1);
      step();
      @(negedge clk);
      check("t5_no_rvalid", if_rvalid_o, 0);
      step();
      rsp_dly = 0;
      if_req_i = 1; if_addr_i = 32'h0000_0700;
      gnt_q.push_back(1'b0);
      exp_rsp(1'b0, 1'b1, 32'hC0DE_0700);
      @(negedge clk);
      check("t5_regrant", if_gnt_o, 1);
      step();
      if_req_i = 0;
      repeat (4) step();

      // Reset while waiting for a MEM response, then a stray response
      rsp_dly = 20;
      mem_req_i = 1; mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h0000_0800;
      gnt_q.push_back(1'b1);
      step();
      mem_req_i = 0;
      step();
      step();
      rst = 1;
      @(negedge clk);
      check("t6_rst_req_side", {if_gnt_o, if_rvalid_o, if_stall_o, mem_gnt_o, mem_rvalid_o, mem_stall_o}, 0);
      step();
      @(negedge clk);
      check("t6_rst_bus_ctl", {bus_req_o, bus_we_o, bus_be_o}, 0);
      check("t6_rst_bus_addr", bus_addr_o, 0);
      step();
      rst = 0;
      stray = 1;
      rsp_dly = 0;
      step();
      @(negedge clk);
      check("t6_stray_rvalid", {if_rvalid_o, mem_rvalid_o}, 0);
      check("t6_stray_busreq", bus_req_o, 0);
      step();
      stray = 0;
      step();
      mem_req_i = 1; mem_addr_i = 32'h0000_0900;
      gnt_q.push_back(1'b1);
      exp_rsp(1'b1, 1'b1, 32'hC0DE_0900);
      @(negedge clk);
      check("t6_idle_regrant", mem_gnt_o, 1);
      step();
      mem_req_i = 0;
      repeat (5) step();

      check("gnt_q_empty", gnt_q.size(), 0);
      check("rsp_q_empty", rsp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (MEM).
- Arbitrates with MEM priority, bounded by an IF anti-starvation limit.
- Sequences one outstanding bus transaction at a time (issue → grant → response).
- Generates the per-requester stall signals that feed the pipeline stall logic, and drops fetch responses invalidated by a redirect.

Parameters:
STARVE_LIMIT, 3, consecutive contested arbitrations MEM may win before IF is forced to win; legal range 1..15
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
if_req_i  in  1  fetch request; held until if_gnt_o
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  one-cycle pulse: IF request accepted
if_rvalid_o  out  1  one-cycle pulse: fetch data valid
if_rdata_o  out  DATA_W  fetch data, valid with if_rvalid_o
if_stall_o  out  1  fetch stage must stall
flush_i  in  1  pipeline redirect; invalidates any in-flight IF transaction
mem_req_i  in  1  load/store request; held until mem_gnt_o
mem_we_i  in  1  1 = store
mem_be_i  in  DATA_W/8  store byte enables
mem_addr_i  in  ADDR_W  load/store address
mem_wdata_i  in  DATA_W  store data
mem_gnt_o  out  1  one-cycle pulse: MEM request accepted
mem_rvalid_o  out  1  one-cycle pulse: load data valid or store acknowledged
mem_rdata_o  out  DATA_W  load data
mem_stall_o  out  1  MEM stage must stall
bus_req_o  out  1  bus request, registered
bus_we_o  out  1  bus write enable, registered
bus_be_o  out  DATA_W/8  bus byte enables, registered (all ones for IF)
bus_addr_o  out  ADDR_W  bus address, registered
bus_wdata_o  out  DATA_W  bus write data, registered
bus_gnt_i  in  1  bus accepted bus_req_o this cycle
bus_rvalid_i  in  1  bus response valid (loads and stores)
bus_rdata_i  in  DATA_W  bus read data

Behaviour:
- Reset: all outputs 0 (bus_* fields 0); state IDLE; owner, drop flag and starve counter cleared.
- FSM states: IDLE, ISSUE, WAIT_RSP.
- IDLE, no request: stay IDLE.
- IDLE, any request:
  - Pick winner; pulse its *_gnt_o combinationally this cycle.
  - Register winner's fields into bus_*; record owner; go to ISSUE.
- Winner selection:
  - Only one requester: that one wins.
  - Both: MEM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins and starve_cnt clears.
  - starve_cnt increments on each contested MEM win; clears on any IF win.
- ISSUE: bus_req_o = 1, all bus_* fields held stable; on bus_gnt_i go to WAIT_RSP and drop bus_req_o next cycle.
- WAIT_RSP: on bus_rvalid_i:
  - Drive owner's *_rvalid_o = 1 and *_rdata_o = bus_rdata_i combinationally in the same cycle.
  - Go to IDLE; new arbitration happens next cycle.
- Latency: minimum 3 cycles from request to rvalid (IDLE → ISSUE → WAIT_RSP with immediate gnt and rvalid).
- rdata outputs are don't-care when the matching rvalid is 0; drive them with bus_rdata_i.
- Writes: bus_we_o = 1; the response pulses mem_rvalid_o and rdata is ignored.
- flush_i:
  - Asserted while owner == IF in ISSUE or WAIT_RSP: set drop flag.
  - The transaction still completes on the bus, but its if_rvalid_o is suppressed; drop flag clears when the response arrives.
  - Asserted in IDLE, or while owner == MEM: no effect.
  - flush_i in the same cycle as bus_rvalid_i for IF: suppress that response.
- Stalls:
  - if_stall_o = if_req_i & ~if_rvalid_o.
  - mem_stall_o = mem_req_i & ~mem_rvalid_o.
  - IF is also stalled while a dropped transaction drains.
- IDLE ignores bus_rvalid_i; a stray response after reset is discarded.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; no rvalid is produced for the aborted transaction.
- A requester dropping its *_req_i before grant is legal: the request is withdrawn and no transaction issues.

Test Plan:
- IF-only fetch at 0x0000_0100, bus_gnt_i/bus_rvalid_i returned immediately with rdata 0x0000_0013 → if_gnt_o pulse in cycle 0; bus_req_o high in cycle 1; if_rvalid_o with 0x0000_0013 in cycle 2; if_stall_o high in cycles 0-1, low in cycle 2.
- Simultaneous IF and MEM load at 0x2000, STARVE_LIMIT = 3 → MEM granted first; IF is granted after the MEM response; starve_cnt = 1.
- MEM and IF both held continuously, MEM re-requesting every cycle → grant order MEM, MEM, MEM, IF, MEM…
- MEM store to 0x3000, be 0b0011, wdata 0xDEAD_BEEF, bus_gnt_i delayed 4 cycles → bus fields stable and bus_req_o high for all 4 cycles; mem_rvalid_o pulses exactly once on bus_rvalid_i.
- IF in WAIT_RSP, flush_i pulsed, response arrives 2 cycles later → no if_rvalid_o pulse; FSM returns to IDLE; the next fetch completes normally.
- rst asserted in WAIT_RSP, followed by a bus_rvalid_i pulse → all outputs 0; no rvalid pulse to IF or MEM; state IDLE.
